// File: rtl/mac_pkg.sv
// Shared types and widths for the mac_dot_seq dot-product sequencer.
package mac_pkg;

    localparam int ACC_W = 16;
    localparam int OP_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mac_term_unit.sv
// Combinational multiply-accumulate term: next_acc = acc + a*b, with carry-out of the add.
// With MAC_DOT_SEQ_SAT_EN defined, an overflowing add clamps next_acc to all ones.
module mac_term_unit
    import mac_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic [ACC_W-1:0] next_acc,
    output logic             carry
);

    logic [ACC_W-1:0] prod;
    logic [ACC_W:0]   sum;

    assign prod  = ACC_W'(a) * ACC_W'(b);
    assign sum   = {1'b0, acc} + {1'b0, prod};
    assign carry = sum[ACC_W];

`ifdef MAC_DOT_SEQ_SAT_EN
    // Once clamped, any further non-zero term overflows again, so acc stays pinned.
    assign next_acc = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign next_acc = sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/mac_dot_seq.sv
// Streaming dot-product sequencer: accepts len operand pairs, returns their 16-bit sum of products.
// Optional MAC_DOT_SEQ_SAT_EN selects saturating accumulation (see mac_term_unit).
//
// state   | meaning
// IDLE    | waiting for start; outputs quiet
// RUN     | accepting operand pairs until the term counter reaches zero
// DONE    | result presented until res_ready
module mac_dot_seq #(
    parameter int LEN_W = 8,
    parameter int ACC_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [LEN_W-1:0]         len,
    input  logic                     abort,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [mac_pkg::OP_W-1:0] in_a,
    input  logic [mac_pkg::OP_W-1:0] in_b,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ACC_W-1:0]         res_data,
    output logic                     busy,
    output logic                     ovf
);

    import mac_pkg::*;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [LEN_W-1:0] cnt, cnt_nxt;
    logic             ovf_q, ovf_nxt;
    logic [ACC_W-1:0] term_acc;
    logic             term_carry;

    mac_term_unit u_term (
        .acc      (acc),
        .a        (in_a),
        .b        (in_b),
        .next_acc (term_acc),
        .carry    (term_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf_q <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf_q;
        if (abort) begin
            state_nxt = ST_IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc_nxt   = '0;
                        ovf_nxt   = 1'b0;
                        cnt_nxt   = len;
                        state_nxt = (len == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (in_valid) begin
                        acc_nxt = term_acc;
                        ovf_nxt = ovf_q | term_carry;
                        cnt_nxt = cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1)) state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Result consumed: a same-cycle start chains straight into the next job.
                    if (res_ready) begin
                        state_nxt = ST_IDLE;
                        if (start) begin
                            acc_nxt   = '0;
                            ovf_nxt   = 1'b0;
                            cnt_nxt   = len;
                            state_nxt = (len == '0) ? ST_DONE : ST_RUN;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_RUN);
    assign res_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign res_data  = acc;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed self-checking bench for mac_dot_seq; expected values are hand-computed per scenario.
module tb_mac_dot_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        busy;
    logic        ovf;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mac_dot_seq #(.LEN_W(8), .ACC_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy),
        .ovf       (ovf)
    );

    // Advance one rising edge and settle 1 ns past it before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; len = 0; abort = 0; in_valid = 0;
        in_a = 0; in_b = 0; res_ready = 0;
        #3;
        tests++;
        if ({busy, in_ready, res_valid, ovf} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: got busy/in_ready/res_valid/ovf=%b want 0000",
                     {busy, in_ready, res_valid, ovf});
        end
        tests++;
        if (res_data !== 16'h0000) begin
            fails++;
            $display("FAIL reset_data: got %h want 0000", res_data);
        end
        step();
        rst_n = 1'b1;
        step();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_basic();
        start = 1; len = 3;
        step();
        start = 0;
        tests++;
        if ({busy, in_ready, res_valid} !== 3'b110) begin
            fails++;
            $display("FAIL basic_run: got busy/in_ready/res_valid=%b want 110",
                     {busy, in_ready, res_valid});
        end
        in_valid = 1; in_a = 2;  in_b = 3;  step();
        in_a = 4;  in_b = 5;  step();
        tests++;
        if (res_valid !== 1'b0 || res_data !== 16'h001A) begin
            fails++;
            $display("FAIL basic_mid: got res_valid=%b data=%h want 0 001a", res_valid, res_data);
        end
        in_a = 10; in_b = 10; step();
        in_valid = 0;
        tests++;
        if (res_valid !== 1'b1 || res_data !== 16'h007E) begin
            fails++;
            $display("FAIL basic_result: got res_valid=%b data=%h want 1 007e", res_valid, res_data);
        end
        tests++;
        if (ovf !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL basic_flags: got ovf=%b in_ready=%b want 0 0", ovf, in_ready);
        end
        res_ready = 1; step(); res_ready = 0;
        tests++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_release: got busy=%b res_valid=%b want 0 0", busy, res_valid);
        end
    endtask

    task automatic test_len_zero();
        bit saw_ready = 0;
        start = 1; len = 0; in_valid = 1; in_a = 9; in_b = 9;
        step();
        start = 0;
        saw_ready = in_ready;
        tests++;
        if (res_valid !== 1'b1 || res_data !== 16'h0000) begin
            fails++;
            $display("FAIL len0_result: got res_valid=%b data=%h want 1 0000", res_valid, res_data);
        end
        step();
        saw_ready = saw_ready | in_ready;
        res_ready = 1; step(); res_ready = 0; in_valid = 0;
        saw_ready = saw_ready | in_ready;
        tests++;
        if (saw_ready !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL len0_ready: got in_ready_seen=%b busy=%b want 0 0", saw_ready, busy);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] exp_data;
`ifdef MAC_DOT_SEQ_SAT_EN
        exp_data = 16'hFFFF;
`else
        exp_data = 16'hFC02;
`endif
        start = 1; len = 2; step(); start = 0;
        in_valid = 1; in_a = 255; in_b = 255; step();
        tests++;
        if (ovf !== 1'b0 || res_data !== 16'hFE01) begin
            fails++;
            $display("FAIL ovf_first: got ovf=%b data=%h want 0 fe01", ovf, res_data);
        end
        step();
        in_valid = 0;
        tests++;
        if (res_valid !== 1'b1 || res_data !== exp_data || ovf !== 1'b1) begin
            fails++;
            $display("FAIL ovf_result: got res_valid=%b data=%h ovf=%b want 1 %h 1",
                     res_valid, res_data, ovf, exp_data);
        end
        // leave the job in DONE with ovf set for the hold test
    endtask

    task automatic test_done_hold();
        int bad = 0;
        logic [15:0] held;
        held = res_data;
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0); len = 5;
            in_valid = 1;
            step();
            if (res_valid !== 1'b1 || in_ready !== 1'b0 || res_data !== held || busy !== 1'b1) bad++;
        end
        start = 0; in_valid = 0;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL done_hold: got %0d unstable cycles want 0 (data=%h held=%h)", bad, res_data, held);
        end
        res_ready = 1; start = 1; len = 1;
        step();
        res_ready = 0; start = 0;
        tests++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 16'h0000 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL done_chain: got in_ready=%b res_valid=%b data=%h ovf=%b want 1 0 0000 0",
                     in_ready, res_valid, res_data, ovf);
        end
        in_valid = 1; in_a = 5; in_b = 6; step(); in_valid = 0;
        tests++;
        if (res_valid !== 1'b1 || res_data !== 16'h001E) begin
            fails++;
            $display("FAIL chain_result: got res_valid=%b data=%h want 1 001e", res_valid, res_data);
        end
        res_ready = 1; step(); res_ready = 0;
    endtask

    task automatic test_abort();
        int seen = 0;
        start = 1; len = 4; step(); start = 0;
        in_valid = 1; in_a = 2; in_b = 2; step();
        tests++;
        if (res_data !== 16'h0004) begin
            fails++;
            $display("FAIL abort_pre: got data=%h want 0004", res_data);
        end
        abort = 1; in_a = 3; in_b = 3; step();
        abort = 0; in_valid = 0;
        tests++;
        if (busy !== 1'b0 || res_data !== 16'h0000 || in_ready !== 1'b0 || res_valid !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle: got busy=%b data=%h in_ready=%b res_valid=%b want 0 0000 0 0",
                     busy, res_data, in_ready, res_valid);
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; step();
            if (res_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        in_valid = 0;
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL abort_quiet: got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        start = 1; len = 3; step(); start = 0;
        in_valid = 1; in_a = 5; in_b = 5; step(); in_valid = 0;
        tests++;
        if (res_data !== 16'h0019 || busy !== 1'b1) begin
            fails++;
            $display("FAIL rst_pre: got data=%h busy=%b want 0019 1", res_data, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, in_ready, res_valid, ovf} !== 4'b0000 || res_data !== 16'h0000) begin
            fails++;
            $display("FAIL rst_async: got flags=%b data=%h want 0000 0000",
                     {busy, in_ready, res_valid, ovf}, res_data);
        end
        step();
        rst_n = 1'b1;
        step(); step();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_wait: got busy=%b want 0", busy);
        end
        start = 1; len = 1; step(); start = 0;
        in_valid = 1; in_a = 7; in_b = 9; step(); in_valid = 0;
        tests++;
        if (res_valid !== 1'b1 || res_data !== 16'h003F) begin
            fails++;
            $display("FAIL rst_newjob: got res_valid=%b data=%h want 1 003f", res_valid, res_data);
        end
        res_ready = 1; step(); res_ready = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_overflow();
        test_done_hold();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
